// File: rtl/intra_pred_pkg.sv
// Shared definitions for the multi-mode intra predictor.
//   - prediction mode codes as carried on the 'mode' port
//   - edge-fill constants used when neighbour pixels are unavailable
//   - one-hot FSM state encoding shared by the top level
package intra_pred_pkg;

    localparam logic [1:0] MODE_DC = 2'd0;
    localparam logic [1:0] MODE_TM = 2'd1;
    localparam logic [1:0] MODE_VE = 2'd2;
    localparam logic [1:0] MODE_HE = 2'd3;

    // Substitute values for missing neighbours (8-bit pixel domain).
    localparam int unsigned FILL_TOP  = 127;
    localparam int unsigned FILL_LEFT = 129;
    localparam int unsigned FILL_DC   = 128;

    // One-hot controller states.
    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_ACC   = 5'b00010,
        S_DCOUT = 5'b00100,
        S_ROW   = 5'b01000,
        S_DONE  = 5'b10000
    } state_t;

endpackage

// File: rtl/intra_pred_row.sv
// Combinational single-row predictor.
// Builds one BLOCK_SIZE-pixel row from the captured neighbours.
//   mode      prediction mode (DC selects the broadcast fill of dc_val)
//   top       captured top row, pixel i at [BW*(i+1)-1:BW*i]
//   left_px   left neighbour of the row being produced
//   top_left  corner pixel, used by TM only
//   dc_val    normalised DC value to broadcast in DC mode
//   top_ok    top neighbours available
//   left_ok   left neighbours available
//   row       resulting row, same packing as top
module intra_pred_row
    import intra_pred_pkg::*;
#(
    parameter int BIT_WIDTH  = 8,
    parameter int BLOCK_SIZE = 16
) (
    input  logic [1:0]                       mode,
    input  logic [BIT_WIDTH*BLOCK_SIZE-1:0]  top,
    input  logic [BIT_WIDTH-1:0]             left_px,
    input  logic [BIT_WIDTH-1:0]             top_left,
    input  logic [BIT_WIDTH-1:0]             dc_val,
    input  logic                             top_ok,
    input  logic                             left_ok,
    output logic [BIT_WIDTH*BLOCK_SIZE-1:0]  row
);

    localparam int BW = BIT_WIDTH;

    // TrueMotion: top + left - corner evaluated two bits wider, then clamped.
    function automatic logic [BIT_WIDTH-1:0] tm_clip(
        input logic [BIT_WIDTH-1:0] t,
        input logic [BIT_WIDTH-1:0] l,
        input logic [BIT_WIDTH-1:0] tl
    );
        logic signed [BIT_WIDTH+1:0] sum_v;
        sum_v = $signed({2'b00, t}) + $signed({2'b00, l}) - $signed({2'b00, tl});
        if (sum_v[BIT_WIDTH+1]) begin
            return '0;
        end else if (sum_v[BIT_WIDTH]) begin
            return '1;
        end else begin
            return sum_v[BIT_WIDTH-1:0];
        end
    endfunction

    logic                 fill_en_s;
    logic                 sel_top_s;
    logic                 sel_left_s;
    logic [BW-1:0]        fill_val_s;

    // Source selection: constant fill, copy top, copy left, or TM arithmetic.
    always_comb begin
        fill_en_s  = 1'b0;
        sel_top_s  = 1'b0;
        sel_left_s = 1'b0;
        fill_val_s = '0;
        case (mode)
            MODE_DC: begin
                fill_en_s  = 1'b1;
                fill_val_s = dc_val;
            end
            MODE_VE: begin
                if (top_ok) begin
                    sel_top_s = 1'b1;
                end else begin
                    fill_en_s  = 1'b1;
                    fill_val_s = BW'(FILL_TOP);
                end
            end
            MODE_HE: begin
                if (left_ok) begin
                    sel_left_s = 1'b1;
                end else begin
                    fill_en_s  = 1'b1;
                    fill_val_s = BW'(FILL_LEFT);
                end
            end
            MODE_TM: begin
                // TM degrades to VE/HE when one side is missing.
                if (top_ok && left_ok) begin
                    fill_en_s = 1'b0;
                end else if (top_ok) begin
                    sel_top_s = 1'b1;
                end else if (left_ok) begin
                    sel_left_s = 1'b1;
                end else begin
                    fill_en_s  = 1'b1;
                    fill_val_s = BW'(FILL_LEFT);
                end
            end
            default: begin
                fill_en_s  = 1'b1;
                fill_val_s = BW'(FILL_DC);
            end
        endcase
    end

    // Per-pixel row assembly from the selected source.
    always_comb begin
        row = '0;
        for (int c = 0; c < BLOCK_SIZE; c++) begin
            if (fill_en_s) begin
                row[c*BW +: BW] = fill_val_s;
            end else if (sel_top_s) begin
                row[c*BW +: BW] = top[c*BW +: BW];
            end else if (sel_left_s) begin
                row[c*BW +: BW] = left_px;
            end else begin
                row[c*BW +: BW] = tm_clip(top[c*BW +: BW], left_px, top_left);
            end
        end
    end

endmodule

// File: rtl/intra_pred_multi.sv
// Multi-mode (DC/TM/VE/HE) intra predictor producing one BSxBS block per start.
//   clk, rst  clock and synchronous active-high reset
//   start     job request, accepted only while idle
//   mode      0=DC 1=TM 2=VE 3=HE
//   x, y      block coordinates; nonzero means left/top neighbours exist
//   top, left neighbour row/column, pixel i at [BW*(i+1)-1:BW*i]
//   top_left  corner pixel for TM
//   dst       predicted block, pixel (r,c) at index r*BS+c (registered)
//   busy      high from the cycle after acceptance through the done cycle
//   done      one-cycle completion pulse; dst valid from here until next start
module intra_pred_multi
    import intra_pred_pkg::*;
#(
    parameter int BIT_WIDTH  = 8,
    parameter int BLOCK_SIZE = 16,
    parameter int BLOCK_NUM  = 10,
    parameter int SHIFT      = 5
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [1:0]                                 mode,
    input  logic [BLOCK_NUM-1:0]                       x,
    input  logic [BLOCK_NUM-1:0]                       y,
    input  logic [BIT_WIDTH*BLOCK_SIZE-1:0]            top,
    input  logic [BIT_WIDTH*BLOCK_SIZE-1:0]            left,
    input  logic [BIT_WIDTH-1:0]                       top_left,
    output logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] dst,
    output logic                                       busy,
    output logic                                       done
);

    localparam int BW    = BIT_WIDTH;
    localparam int BS    = BLOCK_SIZE;
    localparam int ROW_W = BW * BS;
    localparam int SW    = BIT_WIDTH + SHIFT + 1;
    localparam int CW    = (BS > 1) ? $clog2(BS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BS - 1);

    state_t                 state_r;
    logic [CW-1:0]          count_r;
    logic [1:0]             mode_r;
    logic                   top_ok_r;
    logic                   left_ok_r;
    logic [ROW_W-1:0]       top_r;
    logic [ROW_W-1:0]       left_r;
    logic [BW-1:0]          tl_r;
    logic [SW-1:0]          sum_r;
    logic [BW*BS*BS-1:0]    dst_r;
    logic                   busy_r;
    logic                   done_r;

    logic [BW-1:0]          top_px_s;
    logic [BW-1:0]          left_px_s;
    logic [SW-1:0]          add_s;
    logic [BW-1:0]          dc_s;
    logic [ROW_W-1:0]       row_s;

    // Neighbour pixels addressed by the running counter.
    always_comb begin
        top_px_s  = top_r[int'(count_r)*BW +: BW];
        left_px_s = left_r[int'(count_r)*BW +: BW];
    end

    // DC accumulation term; a single available edge is counted twice.
    always_comb begin
        add_s = '0;
        if (top_ok_r && left_ok_r) begin
            add_s = SW'(top_px_s) + SW'(left_px_s);
        end else if (top_ok_r) begin
            add_s = SW'(top_px_s) << 1;
        end else if (left_ok_r) begin
            add_s = SW'(left_px_s) << 1;
        end else begin
            add_s = '0;
        end
    end

    // Rounded DC average.
    always_comb begin
        dc_s = BW'((sum_r + SW'(BS)) >> SHIFT);
    end

    intra_pred_row #(
        .BIT_WIDTH  (BIT_WIDTH),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_row (
        .mode     (mode_r),
        .top      (top_r),
        .left_px  (left_px_s),
        .top_left (tl_r),
        .dc_val   (dc_s),
        .top_ok   (top_ok_r),
        .left_ok  (left_ok_r),
        .row      (row_s)
    );

    // Controller, input capture, DC accumulator and block register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            count_r   <= '0;
            mode_r    <= MODE_DC;
            top_ok_r  <= 1'b0;
            left_ok_r <= 1'b0;
            top_r     <= '0;
            left_r    <= '0;
            tl_r      <= '0;
            sum_r     <= '0;
            dst_r     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r  <= 1'b0;
                    count_r <= '0;
                    if (start) begin
                        mode_r    <= mode;
                        top_ok_r  <= (y != '0);
                        left_ok_r <= (x != '0);
                        top_r     <= top;
                        left_r    <= left;
                        tl_r      <= top_left;
                        busy_r    <= 1'b1;
                        if (mode != MODE_DC) begin
                            sum_r   <= '0;
                            state_r <= S_ROW;
                        end else if ((x == '0) && (y == '0)) begin
                            // No neighbours: preload so the rounded average is 128.
                            sum_r   <= SW'(FILL_DC) << SHIFT;
                            state_r <= S_DCOUT;
                        end else begin
                            sum_r   <= '0;
                            state_r <= S_ACC;
                        end
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                S_ACC: begin
                    sum_r <= sum_r + add_s;
                    if (count_r == LAST_CNT) begin
                        count_r <= '0;
                        state_r <= S_DCOUT;
                    end else begin
                        count_r <= count_r + CW'(1);
                    end
                end
                S_DCOUT: begin
                    dst_r   <= {BS{row_s}};
                    done_r  <= 1'b1;
                    state_r <= S_DONE;
                end
                S_ROW: begin
                    dst_r[int'(count_r)*ROW_W +: ROW_W] <= row_s;
                    if (count_r == LAST_CNT) begin
                        count_r <= '0;
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        count_r <= count_r + CW'(1);
                    end
                end
                S_DONE: begin
                    count_r <= '0;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    count_r <= '0;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign dst  = dst_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_intra_pred_multi.sv
// Self-checking bench: three predictors (BS=4, 8, 16) share stimulus; a
// behavioural model computes expected blocks, busy and done per instance.
module tb_intra_pred_multi;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   mode;
    logic [9:0]   x;
    logic [9:0]   y;
    logic [127:0] top;
    logic [127:0] left;
    logic [7:0]   tl;
    logic [127:0]  dst4;
    logic [511:0]  dst8;
    logic [2047:0] dst16;
    logic [2:0]   busy_v;
    logic [2:0]   done_v;

    always #5 clk = ~clk;

    intra_pred_multi #(.BIT_WIDTH(8), .BLOCK_SIZE(4), .BLOCK_NUM(10), .SHIFT(3)) u_bs4 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .x(x), .y(y),
        .top(top[31:0]), .left(left[31:0]), .top_left(tl),
        .dst(dst4), .busy(busy_v[0]), .done(done_v[0]));
    intra_pred_multi #(.BIT_WIDTH(8), .BLOCK_SIZE(8), .BLOCK_NUM(10), .SHIFT(4)) u_bs8 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .x(x), .y(y),
        .top(top[63:0]), .left(left[63:0]), .top_left(tl),
        .dst(dst8), .busy(busy_v[1]), .done(done_v[1]));
    intra_pred_multi #(.BIT_WIDTH(8), .BLOCK_SIZE(16), .BLOCK_NUM(10), .SHIFT(5)) u_bs16 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .x(x), .y(y),
        .top(top), .left(left), .top_left(tl),
        .dst(dst16), .busy(busy_v[2]), .done(done_v[2]));

    int  chk_cnt = 0;
    int  pass_cnt = 0;
    int  cyc = 0;
    bit  chk_en = 1'b0;
    bit  mbusy [3];
    int  tacc [3];
    int  lat [3];
    int  oldb [3][16][16];
    int  newb [3][16][16];
    int  sw [3][16];
    int  t0;
    int  done_at [3];
    int  busy_hi;

    function automatic int bs_of(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 8 : 16);
    endfunction

    function automatic int sh_of(input int k);
        return (k == 0) ? 3 : ((k == 1) ? 4 : 5);
    endfunction

    function automatic int lat_of(input int k, input int md, input bit tv, input bit lv);
        if (md == 0) return (tv || lv) ? bs_of(k) + 2 : 2;
        return bs_of(k) + 1;
    endfunction

    // Spec-level pixel value computed from the current inputs.
    function automatic int ref_pix(input int k, input int md, input bit tv, input bit lv,
                                   input int r, input int c);
        int b;
        int s;
        int tc;
        int lr;
        b  = bs_of(k);
        tc = int'(top[8*c +: 8]);
        lr = int'(left[8*r +: 8]);
        case (md)
            0: begin
                s = 0;
                if (!tv && !lv) s = 128 << sh_of(k);
                else for (int i = 0; i < b; i++) begin
                    if (tv && lv) s += int'(top[8*i +: 8]) + int'(left[8*i +: 8]);
                    else if (tv) s += 2 * int'(top[8*i +: 8]);
                    else s += 2 * int'(left[8*i +: 8]);
                end
                return (s + b) >> sh_of(k);
            end
            2: return tv ? tc : 127;
            3: return lv ? lr : 129;
            default: begin
                if (tv && lv) begin
                    s = tc + lr - int'(tl);
                    return (s < 0) ? 0 : ((s > 255) ? 255 : s);
                end
                if (tv) return tc;
                if (lv) return lr;
                return 129;
            end
        endcase
    endfunction

    function automatic int dst_pix(input int k, input int r, input int c);
        int i;
        i = (r * bs_of(k) + c) * 8;
        if (k == 0) return int'(dst4[i +: 8]);
        if (k == 1) return int'(dst8[i +: 8]);
        return int'(dst16[i +: 8]);
    endfunction

    function automatic int exp_pix(input int k, input int r, input int c);
        return (cyc >= sw[k][r]) ? newb[k][r][c] : oldb[k][r][c];
    endfunction

    task automatic check_val(input string nm, input int k, input int got, input int want);
        chk_cnt++;
        if (got == want) pass_cnt++;
        else $display("FAIL %s inst%0d cyc=%0d got=%0d want=%0d", nm, k, cyc, got, want);
    endtask

    task automatic check_dst(input int k);
        int br;
        int bc;
        br = -1;
        bc = -1;
        for (int r = 0; r < bs_of(k); r++)
            for (int c = 0; c < bs_of(k); c++)
                if (br < 0 && dst_pix(k, r, c) != exp_pix(k, r, c)) begin
                    br = r;
                    bc = c;
                end
        chk_cnt++;
        if (br < 0) pass_cnt++;
        else $display("FAIL dst inst%0d cyc=%0d pixel(%0d,%0d) got=%0d want=%0d",
                      k, cyc, br, bc, dst_pix(k, br, bc), exp_pix(k, br, bc));
    endtask

    // Behavioural model: job acceptance, latency window and expected block.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                mbusy[k] <= 1'b0;
                for (int r = 0; r < 16; r++) begin
                    sw[k][r] <= 0;
                    for (int c = 0; c < 16; c++) begin
                        oldb[k][r][c] <= 0;
                        newb[k][r][c] <= 0;
                    end
                end
            end else if (!mbusy[k] && start) begin
                mbusy[k] <= 1'b1;
                tacc[k]  <= cyc;
                lat[k]   <= lat_of(k, int'(mode), y != 0, x != 0);
                for (int r = 0; r < 16; r++) begin
                    sw[k][r] <= (mode == 2'd0) ? cyc + lat_of(k, 0, y != 0, x != 0) : cyc + 2 + r;
                    for (int c = 0; c < 16; c++) begin
                        oldb[k][r][c] <= newb[k][r][c];
                        newb[k][r][c] <= (r < bs_of(k) && c < bs_of(k)) ?
                                         ref_pix(k, int'(mode), y != 0, x != 0, r, c) : 0;
                    end
                end
            end else if (mbusy[k] && cyc == tacc[k] + lat[k]) begin
                mbusy[k] <= 1'b0;
            end
        end
        if (rst) chk_en <= 1'b1;
        cyc <= cyc + 1;
    end

    // Every-cycle comparison of busy, done and dst against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                check_val("busy", k, int'(busy_v[k]), int'(mbusy[k]));
                check_val("done", k, int'(done_v[k]), int'(mbusy[k] && cyc == tacc[k] + lat[k]));
                check_dst(k);
            end
        end
    end

    function automatic logic [127:0] const_row(input int v);
        logic [127:0] rv;
        for (int i = 0; i < 16; i++) rv[8*i +: 8] = 8'(v);
        return rv;
    endfunction

    task automatic scramble(input bit keep_cfg);
        top  = {$urandom, $urandom, $urandom, $urandom};
        left = {$urandom, $urandom, $urandom, $urandom};
        tl   = 8'($urandom);
        if (!keep_cfg) begin
            mode = 2'($urandom);
            x    = 10'($urandom);
            y    = 10'($urandom);
        end
    endtask

    // One job: pulse start, scramble inputs afterwards, record done cycles.
    task automatic run_job(input int md, input int xx, input int yy, input logic [127:0] tp,
                           input logic [127:0] lf, input int tlv);
        @(negedge clk);
        mode = 2'(md); x = 10'(xx); y = 10'(yy); top = tp; left = lf; tl = 8'(tlv);
        start = 1'b1;
        t0 = cyc;
        busy_hi = 0;
        for (int k = 0; k < 3; k++) done_at[k] = -1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 3; k++) if (done_v[k] && done_at[k] < 0) done_at[k] = cyc;
            if (busy_v[2]) busy_hi++;
            if (done_at[0] >= 0 && done_at[1] >= 0 && done_at[2] >= 0 && busy_v == 3'b000) break;
            scramble(1'b0);
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++)
            check_val("latency", k, done_at[k] - t0, lat_of(k, md, yy != 0, xx != 0));
    endtask

    logic [127:0] ramp;
    int           d1 [3];
    int           d2 [3];

    initial begin
        rst = 1'b1; start = 1'b0; mode = 2'd0; x = '0; y = '0;
        top = '0; left = '0; tl = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_val("rst_busy", 2, int'(busy_v[2]), 0);
        check_val("rst_dst", 2, dst_pix(2, 15, 15), 0);

        // DC with both edges: every pixel 20.
        run_job(0, 1, 1, const_row(10), const_row(30), 0);
        check_val("dc_lat16", 2, done_at[2] - t0, 18);
        check_val("dc_lat4", 0, done_at[0] - t0, 6);
        check_val("dc_lat8", 1, done_at[1] - t0, 10);
        check_val("dc_busy_cycles", 2, busy_hi, 18);
        check_val("dc_px", 2, dst_pix(2, 5, 7), 20);
        check_val("dc_px", 0, dst_pix(0, 3, 3), 20);

        // No neighbours: DC 128 at T+2, VE 127, HE 129.
        run_job(0, 0, 0, const_row(77), const_row(99), 0);
        check_val("dc_none_lat", 2, done_at[2] - t0, 2);
        check_val("dc_none_px", 2, dst_pix(2, 9, 4), 128);
        run_job(2, 5, 0, const_row(77), const_row(99), 0);
        check_val("ve_fill", 1, dst_pix(1, 7, 0), 127);
        check_val("ve_lat16", 2, done_at[2] - t0, 17);
        run_job(3, 0, 3, const_row(77), const_row(99), 0);
        check_val("he_fill", 2, dst_pix(2, 0, 15), 129);

        // TM ramp with high clip, then low clip.
        for (int c = 0; c < 16; c++) ramp[8*c +: 8] = 8'(c * 16);
        run_job(1, 1, 1, ramp, const_row(200), 100);
        check_val("tm_px", 2, dst_pix(2, 0, 9), 244);
        check_val("tm_clip_hi", 2, dst_pix(2, 7, 10), 255);
        check_val("tm_px", 0, dst_pix(0, 1, 3), 148);
        check_val("tm_lat4", 0, done_at[0] - t0, 5);
        check_val("tm_lat8", 1, done_at[1] - t0, 9);
        run_job(1, 2, 2, const_row(0), const_row(0), 255);
        check_val("tm_clip_lo", 2, dst_pix(2, 4, 4), 0);

        // start held high: re-accept only at the idle cycle after done.
        @(negedge clk);
        mode = 2'd2; x = 10'd3; y = 10'd3; start = 1'b1;
        for (int k = 0; k < 3; k++) begin d1[k] = -1; d2[k] = -1; end
        for (int n = 0; n < 60; n++) begin
            for (int k = 0; k < 3; k++)
                if (done_v[k]) begin
                    if (d1[k] < 0) d1[k] = cyc;
                    else if (d2[k] < 0) d2[k] = cyc;
                end
            scramble(1'b1);
            @(negedge clk);
        end
        start = 1'b0;
        for (int k = 0; k < 3; k++) check_val("held_spacing", k, d2[k] - d1[k], bs_of(k) + 2);
        for (int n = 0; n < 40 && busy_v != 3'b000; n++) @(negedge clk);
        check_val("held_drain", 2, int'(busy_v), 0);

        // Reset in the middle of a row job.
        @(negedge clk);
        mode = 2'd1; x = 10'd1; y = 10'd1; top = ramp; left = const_row(50); tl = 8'd20;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort_busy", 2, int'(busy_v[2]), 0);
        check_val("abort_dst", 2, dst_pix(2, 0, 3), 0);
        repeat (20) begin
            @(negedge clk);
            check_val("abort_no_done", 2, int'(done_v[2]), 0);
        end
        run_job(0, 1, 1, const_row(10), const_row(30), 0);
        check_val("post_abort_px", 2, dst_pix(2, 15, 0), 20);

        // Randomized jobs against the model.
        for (int j = 0; j < 30; j++) begin
            run_job(int'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 1023)),
                    ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 1023)),
                    {$urandom, $urandom, $urandom, $urandom},
                    {$urandom, $urandom, $urandom, $urandom},
                    int'($urandom_range(0, 255)));
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1);
    end

endmodule
